flash_rd_seq: RTL

// Read sequencer directly upstream of the flash array macro. Accepts a byte-granular read request
// (start address, length), drives analog_on/eq/mem_addr to fetch 128-bit lines from the array,

---
 rtl/flash_rd_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/flash_rd_seq.sv
// Flash array read sequencer: fetches 128-bit lines and streams bytes on a valid/ready port.
// Optional FLASH_RD_ABORT_EN adds rd_abort to cancel an in-flight read.
module flash_rd_seq #(
  parameter int unsigned ANA_SETUP = 2,  // >= 1
  parameter int unsigned EQ_CYC    = 2,  // >= 1
  parameter int unsigned RD_WAIT   = 6   // >= EQ_CYC, >= 5
) (
  input  logic         clkm,
  input  logic         rst_n,
  input  logic         rd_req,
  input  logic [21:0]  rd_addr,
  input  logic [8:0]   rd_len,
  output logic         rd_ack,
  output logic         rd_busy,
  output logic         rd_done,
  output logic         analog_on,
  output logic         eq,
  output logic [21:0]  mem_addr,
  input  logic [127:0] mem_data,
  output logic         byte_valid,
  input  logic         byte_ready,
`ifdef FLASH_RD_ABORT_EN
  input  logic         rd_abort,
`endif
  output logic [7:0]   byte_data
);

  typedef enum logic [2:0] {StIdle, StPwrup, StEq, StWait, StStream, StDone} state_e;

  localparam logic [7:0] LpAnaLast = 8'(ANA_SETUP - 1);
  localparam logic [7:0] LpEqCyc   = 8'(EQ_CYC);
  localparam logic [7:0] LpRdWait  = 8'(RD_WAIT);

  state_e       r_state;
  logic [7:0]   r_cnt;
  logic [17:0]  r_line_addr;
  logic [3:0]   r_idx;
  logic [8:0]   r_rem;
  logic [127:0] r_line;
  logic         r_ack;
  logic         r_busy;
  logic         r_done;
  logic         r_ana;
  logic         r_eq;
  logic         r_valid;
  logic [7:0]   r_data;

  logic         w_abort;
  logic         w_hs;
  logic [3:0]   w_idx_nxt;
  logic [7:0]   w_cap_byte;
  logic [7:0]   w_nxt_byte;

`ifdef FLASH_RD_ABORT_EN
  assign w_abort = rd_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_hs       = r_valid & byte_ready;
  assign w_idx_nxt  = r_idx + 4'd1;
  assign w_cap_byte = mem_data[{r_idx, 3'b000} +: 8];
  assign w_nxt_byte = r_line[{w_idx_nxt, 3'b000} +: 8];

  always_ff @(posedge clkm or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_line_addr <= '0;
      r_idx       <= '0;
      r_rem       <= '0;
      r_line      <= '0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ana       <= 1'b0;
      r_eq        <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (w_abort && (r_state != StIdle)) begin
        // Abort beats any handshake in the same cycle: no rd_done.
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_ana   <= 1'b0;
        r_eq    <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (rd_req) begin
              r_state     <= StPwrup;
              r_ack       <= 1'b1;
              r_busy      <= 1'b1;
              r_ana       <= 1'b1;
              r_line_addr <= rd_addr[21:4];
              r_idx       <= rd_addr[3:0];
              r_rem       <= (rd_len == 9'd0) ? 9'd256 : rd_len;
              r_cnt       <= '0;
            end
          end
          StPwrup: begin
            if (r_cnt == LpAnaLast) begin
              r_state <= StEq;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          // r_cnt counts edges since eq rose; count 0 is the rise edge itself.
          StEq, StWait: begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'd0) begin
              r_eq <= 1'b1;
            end
            if (r_cnt == LpEqCyc) begin
              r_eq    <= 1'b0;
              r_state <= StWait;
            end
            if (r_cnt == LpRdWait) begin
              r_eq    <= 1'b0;
              r_line  <= mem_data;
              r_data  <= w_cap_byte;
              r_valid <= 1'b1;
              r_state <= StStream;
            end
          end
          StStream: begin
            if (w_hs) begin
              r_rem <= r_rem - 9'd1;
              if (r_rem == 9'd1) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_state <= StDone;
              end else if (r_idx == 4'hF) begin
                // Line exhausted: refetch next line with the array still powered.
                r_idx       <= '0;
                r_line_addr <= r_line_addr + 18'd1;
                r_valid     <= 1'b0;
                r_cnt       <= '0;
                r_state     <= StEq;
              end else begin
                r_idx  <= w_idx_nxt;
                r_data <= w_nxt_byte;
              end
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_ana   <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign rd_ack     = r_ack;
  assign rd_busy    = r_busy;
  assign rd_done    = r_done;
  assign analog_on  = r_ana;
  assign eq         = r_eq;
  assign mem_addr   = {r_line_addr, 4'h0};
  assign byte_valid = r_valid;
  assign byte_data  = r_data;

endmodule
